// File: rtl/swerv_trace_fifo.sv
// rtl/swerv_trace_fifo.sv - retire-trace FIFO: up to LANES records in per cycle, one out
// Groups that do not fit are dropped whole; the loss is counted and flagged on the next stored record.
module swerv_trace_fifo #(
  parameter int LANES = 3,
  parameter int DEPTH = 8,
  parameter int CNTW  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       trace_en,
  input  logic                       flush,
  input  logic [LANES-1:0]           in_valid,
  input  logic [32*LANES-1:0]        in_insn,
  input  logic [32*LANES-1:0]        in_addr,
  input  logic [LANES-1:0]           in_exception,
  input  logic [LANES-1:0]           in_interrupt,
  input  logic [4:0]                 in_ecause,
  input  logic [31:0]                in_tval,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_insn,
  output logic [31:0]                out_addr,
  output logic                       out_exception,
  output logic                       out_interrupt,
  output logic [4:0]                 out_ecause,
  output logic [31:0]                out_tval,
  output logic [1:0]                 out_lane,
  output logic                       out_ovf,
  output logic [CNTW-1:0]            drop_cnt,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(DEPTH+1);
  localparam int NENT = 2**PW;
  localparam int DW   = CNTW + 1;

  logic [31:0]     r_insn   [NENT];
  logic [31:0]     r_addr   [NENT];
  logic            r_exc    [NENT];
  logic            r_int    [NENT];
  logic [4:0]      r_ecause [NENT];
  logic [31:0]     r_tval   [NENT];
  logic [1:0]      r_lane   [NENT];
  logic            r_ovf    [NENT];

  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_ovf_pend;
  logic [CNTW-1:0] r_drop_cnt;

  logic [LANES-1:0] w_vmask;
  logic [LANES-1:0] w_first;
  logic [PW-1:0]    w_slot [LANES];
  logic [CW-1:0]    w_n;
  logic [CW-1:0]    w_free;
  logic [DW-1:0]    w_dsum;
  logic             w_push;
  logic             w_drop;
  logic             w_pop;

  // Compaction: each valid lane lands at wptr + (number of valid lanes below it).
  always_comb begin
    w_vmask = in_valid & {LANES{trace_en}};
    w_n     = '0;
    w_first = '0;
    for (int i = 0; i < LANES; i++) begin
      w_slot[i]  = r_wptr + w_n[PW-1:0];
      w_first[i] = w_vmask[i] && (w_n == '0);
      if (w_vmask[i]) w_n = w_n + CW'(1);
    end
  end

  // Free space ignores a same-cycle pop, so a full FIFO drops even while draining.
  assign w_free = CW'(DEPTH) - r_count;
  assign w_push = !flush && (w_n != '0) && (w_n <= w_free);
  assign w_drop = !flush && (w_n != '0) && (w_n > w_free);
  assign w_pop  = !flush && (r_count != '0) && out_ready;
  assign w_dsum = {1'b0, r_drop_cnt} + DW'(w_n);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_ovf_pend <= 1'b0;
      r_drop_cnt <= '0;
    end else if (flush) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_ovf_pend <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + w_n[PW-1:0];
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + (w_push ? w_n : CW'(0)) - (w_pop ? CW'(1) : CW'(0));
      if (w_drop) begin
        r_ovf_pend <= 1'b1;
        r_drop_cnt <= w_dsum[CNTW] ? {CNTW{1'b1}} : w_dsum[CNTW-1:0];
      end else if (w_push) begin
        r_ovf_pend <= 1'b0;
      end
    end
  end

  // Record storage carries no reset; out_* are gated by occupancy instead.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (w_push && w_vmask[i]) begin
        r_insn[w_slot[i]]   <= in_insn[32*i +: 32];
        r_addr[w_slot[i]]   <= in_addr[32*i +: 32];
        r_exc[w_slot[i]]    <= in_exception[i];
        r_int[w_slot[i]]    <= in_interrupt[i];
        r_lane[w_slot[i]]   <= 2'(i);
        r_ovf[w_slot[i]]    <= w_first[i] && r_ovf_pend;
        r_ecause[w_slot[i]] <= (in_exception[i] || in_interrupt[i]) ? in_ecause : 5'd0;
        r_tval[w_slot[i]]   <= (in_exception[i] || in_interrupt[i]) ? in_tval : 32'd0;
      end
    end
  end

  assign out_valid     = (r_count != '0);
  assign out_insn      = out_valid ? r_insn[r_rptr]   : 32'd0;
  assign out_addr      = out_valid ? r_addr[r_rptr]   : 32'd0;
  assign out_exception = out_valid ? r_exc[r_rptr]    : 1'b0;
  assign out_interrupt = out_valid ? r_int[r_rptr]    : 1'b0;
  assign out_ecause    = out_valid ? r_ecause[r_rptr] : 5'd0;
  assign out_tval      = out_valid ? r_tval[r_rptr]   : 32'd0;
  assign out_lane      = out_valid ? r_lane[r_rptr]   : 2'd0;
  assign out_ovf       = out_valid ? r_ovf[r_rptr]    : 1'b0;
  assign drop_cnt      = r_drop_cnt;
  assign count         = r_count;

endmodule

// File: tb/tb_swerv_trace_fifo.sv
// tb/tb_swerv_trace_fifo.sv - directed table-driven bench for swerv_trace_fifo
// LANES=3, DEPTH=8, CNTW=4 so the drop counter saturates within a short run.
module tb_swerv_trace_fifo;

  localparam int LANES = 3;
  localparam int DEPTH = 8;
  localparam int CNTW  = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                trace_en;
  logic                flush;
  logic [LANES-1:0]    in_valid;
  logic [32*LANES-1:0] in_insn;
  logic [32*LANES-1:0] in_addr;
  logic [LANES-1:0]    in_exception;
  logic [LANES-1:0]    in_interrupt;
  logic [4:0]          in_ecause;
  logic [31:0]         in_tval;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_insn;
  logic [31:0]         out_addr;
  logic                out_exception;
  logic                out_interrupt;
  logic [4:0]          out_ecause;
  logic [31:0]         out_tval;
  logic [1:0]          out_lane;
  logic                out_ovf;
  logic [CNTW-1:0]     drop_cnt;
  logic [3:0]          count;

  int errors = 0;
  int checks = 0;

  swerv_trace_fifo #(.LANES(LANES), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .trace_en(trace_en), .flush(flush),
    .in_valid(in_valid), .in_insn(in_insn), .in_addr(in_addr),
    .in_exception(in_exception), .in_interrupt(in_interrupt),
    .in_ecause(in_ecause), .in_tval(in_tval),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_insn(out_insn), .out_addr(out_addr),
    .out_exception(out_exception), .out_interrupt(out_interrupt),
    .out_ecause(out_ecause), .out_tval(out_tval), .out_lane(out_lane),
    .out_ovf(out_ovf), .drop_cnt(drop_cnt), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [2:0] v;
    logic [7:0] tag;
    logic       rdy;
    logic       fl;
    logic [3:0] cnt;
    logic       ov;
    logic [7:0] etag;
    logic [1:0] elane;
    logic       eovf;
    logic [3:0] dc;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] mk_insn(input logic [7:0] tag, input int lane);
    return {tag, 16'h0013, 8'(lane)};
  endfunction

  function automatic logic [31:0] mk_addr(input logic [7:0] tag, input int lane);
    return {16'h8000, tag, 8'(lane * 4)};
  endfunction

  function automatic vec_t mk(input logic en, input logic [2:0] v, input logic [7:0] tag,
                              input logic rdy, input logic fl, input logic [3:0] cnt,
                              input logic ov, input logic [7:0] etag, input logic [1:0] elane,
                              input logic eovf, input logic [3:0] dc);
    vec_t r;
    r.en = en; r.v = v; r.tag = tag; r.rdy = rdy; r.fl = fl; r.cnt = cnt;
    r.ov = ov; r.etag = etag; r.elane = elane; r.eovf = eovf; r.dc = dc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [2:0] v, input logic [7:0] tag,
                       input logic rdy, input logic fl);
    trace_en  = en;
    in_valid  = v;
    out_ready = rdy;
    flush     = fl;
    for (int i = 0; i < LANES; i++) begin
      in_insn[32*i +: 32] = mk_insn(tag, i);
      in_addr[32*i +: 32] = mk_addr(tag, i);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag_s, input logic [3:0] cnt, input logic ov,
                            input logic [7:0] etag, input logic [1:0] elane,
                            input logic eovf, input logic [3:0] dc);
    chk({tag_s, ".count"},     64'(count),     64'(cnt));
    chk({tag_s, ".out_valid"}, 64'(out_valid), 64'(ov));
    chk({tag_s, ".out_insn"},  64'(out_insn),  ov ? 64'(mk_insn(etag, int'(elane))) : 64'd0);
    chk({tag_s, ".out_addr"},  64'(out_addr),  ov ? 64'(mk_addr(etag, int'(elane))) : 64'd0);
    chk({tag_s, ".out_lane"},  64'(out_lane),  ov ? 64'(elane) : 64'd0);
    chk({tag_s, ".out_ovf"},   64'(out_ovf),   64'(ov && eovf));
    chk({tag_s, ".drop_cnt"},  64'(drop_cnt),  64'(dc));
  endtask

  task automatic run_tbl(input string name);
    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].en, tbl[k].v, tbl[k].tag, tbl[k].rdy, tbl[k].fl);
      cycle();
      check_head($sformatf("%s[%0d]", name, k), tbl[k].cnt, tbl[k].ov,
                 tbl[k].etag, tbl[k].elane, tbl[k].eovf, tbl[k].dc);
    end
    tbl.delete();
  endtask

  initial begin
    rst = 1'b1;
    in_exception = '0;
    in_interrupt = '0;
    in_ecause    = '0;
    in_tval      = '0;
    drive(1'b1, 3'b000, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_head("reset", 4'd0, 1'b0, 8'h00, 2'd0, 1'b0, 4'd0);
    chk("reset.out_tval", 64'(out_tval), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    //            en  v       tag    rdy fl  cnt ov etag  ln ovf dc
    tbl.push_back(mk(1, 3'b101, 8'h01, 1, 0, 2, 1, 8'h01, 0, 0, 0));
    tbl.push_back(mk(1, 3'b000, 8'h00, 1, 0, 1, 1, 8'h01, 2, 0, 0));
    tbl.push_back(mk(1, 3'b000, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 3'b111, 8'h02, 0, 0, 3, 1, 8'h02, 0, 0, 0));
    tbl.push_back(mk(1, 3'b111, 8'h03, 0, 0, 6, 1, 8'h02, 0, 0, 0));
    tbl.push_back(mk(1, 3'b111, 8'h04, 0, 0, 6, 1, 8'h02, 0, 0, 3));
    tbl.push_back(mk(1, 3'b001, 8'h05, 0, 0, 7, 1, 8'h02, 0, 0, 3));
    tbl.push_back(mk(1, 3'b000, 8'h00, 1, 0, 6, 1, 8'h02, 1, 0, 3));
    tbl.push_back(mk(1, 3'b000, 8'h00, 1, 0, 5, 1, 8'h02, 2, 0, 3));
    tbl.push_back(mk(1, 3'b000, 8'h00, 1, 0, 4, 1, 8'h03, 0, 0, 3));
    tbl.push_back(mk(1, 3'b000, 8'h00, 1, 0, 3, 1, 8'h03, 1, 0, 3));
    tbl.push_back(mk(1, 3'b000, 8'h00, 1, 0, 2, 1, 8'h03, 2, 0, 3));
    tbl.push_back(mk(1, 3'b000, 8'h00, 1, 0, 1, 1, 8'h05, 0, 1, 3));
    tbl.push_back(mk(1, 3'b000, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 3));
    tbl.push_back(mk(1, 3'b111, 8'h06, 0, 0, 3, 1, 8'h06, 0, 0, 3));
    tbl.push_back(mk(1, 3'b111, 8'h07, 0, 0, 6, 1, 8'h06, 0, 0, 3));
    tbl.push_back(mk(1, 3'b011, 8'h08, 0, 0, 8, 1, 8'h06, 0, 0, 3));
    tbl.push_back(mk(1, 3'b001, 8'h09, 1, 0, 7, 1, 8'h06, 1, 0, 4));
    tbl.push_back(mk(1, 3'b001, 8'h0A, 1, 0, 7, 1, 8'h06, 2, 0, 4));
    tbl.push_back(mk(0, 3'b111, 8'h0B, 0, 0, 7, 1, 8'h06, 2, 0, 4));
    tbl.push_back(mk(0, 3'b111, 8'h0C, 1, 0, 6, 1, 8'h07, 0, 0, 4));
    tbl.push_back(mk(0, 3'b111, 8'h0D, 1, 0, 5, 1, 8'h07, 1, 0, 4));
    tbl.push_back(mk(1, 3'b000, 8'h00, 1, 0, 4, 1, 8'h07, 2, 0, 4));
    tbl.push_back(mk(1, 3'b000, 8'h00, 1, 0, 3, 1, 8'h08, 0, 0, 4));
    tbl.push_back(mk(1, 3'b000, 8'h00, 1, 0, 2, 1, 8'h08, 1, 0, 4));
    tbl.push_back(mk(1, 3'b000, 8'h00, 1, 0, 1, 1, 8'h0A, 0, 1, 4));
    tbl.push_back(mk(1, 3'b000, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 4));
    run_tbl("basic");

    // Trap fields: only trapping lanes keep ecause/tval.
    drive(1'b1, 3'b111, 8'h30, 1'b0, 1'b0);
    in_exception = 3'b010;
    in_interrupt = 3'b100;
    in_ecause    = 5'd2;
    in_tval      = 32'hDEAD_BEEF;
    cycle();
    in_exception = '0;
    in_interrupt = '0;
    in_ecause    = '0;
    in_tval      = '0;
    check_head("trap0", 4'd3, 1'b1, 8'h30, 2'd0, 1'b0, 4'd4);
    chk("trap0.exc",    64'(out_exception), 64'd0);
    chk("trap0.ecause", 64'(out_ecause),    64'd0);
    chk("trap0.tval",   64'(out_tval),      64'd0);
    drive(1'b1, 3'b000, 8'h00, 1'b1, 1'b0);
    cycle();
    check_head("trap1", 4'd2, 1'b1, 8'h30, 2'd1, 1'b0, 4'd4);
    chk("trap1.exc",    64'(out_exception), 64'd1);
    chk("trap1.int",    64'(out_interrupt), 64'd0);
    chk("trap1.ecause", 64'(out_ecause),    64'd2);
    chk("trap1.tval",   64'(out_tval),      64'hDEAD_BEEF);
    cycle();
    chk("trap2.exc",    64'(out_exception), 64'd0);
    chk("trap2.int",    64'(out_interrupt), 64'd1);
    chk("trap2.ecause", 64'(out_ecause),    64'd2);
    chk("trap2.tval",   64'(out_tval),      64'hDEAD_BEEF);
    cycle();
    chk("trap_empty.valid",  64'(out_valid),  64'd0);
    chk("trap_empty.ecause", 64'(out_ecause), 64'd0);
    chk("trap_empty.tval",   64'(out_tval),   64'd0);

    // Steady stream: one in, one out, pointers wrap several times.
    drive(1'b1, 3'b001, 8'h40, 1'b1, 1'b0);
    cycle();
    check_head("wrap0", 4'd1, 1'b1, 8'h40, 2'd0, 1'b0, 4'd4);
    for (int k = 1; k <= 20; k++) begin
      drive(1'b1, 3'b001, 8'(8'h40 + k), 1'b1, 1'b0);
      cycle();
      chk($sformatf("wrap%0d.count", k), 64'(count), 64'd1);
      chk($sformatf("wrap%0d.insn", k), 64'(out_insn), 64'(mk_insn(8'(8'h40 + k), 0)));
    end
    drive(1'b1, 3'b000, 8'h00, 1'b1, 1'b0);
    cycle();
    chk("wrap_end.count", 64'(count), 64'd0);

    tbl.push_back(mk(1, 3'b111, 8'h50, 0, 0, 3, 1, 8'h50, 0, 0, 4));
    tbl.push_back(mk(1, 3'b111, 8'h51, 0, 0, 6, 1, 8'h50, 0, 0, 4));
    tbl.push_back(mk(1, 3'b011, 8'h52, 0, 0, 8, 1, 8'h50, 0, 0, 4));
    tbl.push_back(mk(1, 3'b111, 8'h53, 1, 1, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 3'b111, 8'h60, 0, 0, 3, 1, 8'h60, 0, 0, 0));
    tbl.push_back(mk(1, 3'b111, 8'h61, 0, 0, 6, 1, 8'h60, 0, 0, 0));
    tbl.push_back(mk(1, 3'b011, 8'h62, 0, 0, 8, 1, 8'h60, 0, 0, 0));
    tbl.push_back(mk(1, 3'b111, 8'h63, 0, 0, 8, 1, 8'h60, 0, 0, 3));
    tbl.push_back(mk(1, 3'b111, 8'h64, 0, 0, 8, 1, 8'h60, 0, 0, 6));
    tbl.push_back(mk(1, 3'b111, 8'h65, 0, 0, 8, 1, 8'h60, 0, 0, 9));
    tbl.push_back(mk(1, 3'b111, 8'h66, 0, 0, 8, 1, 8'h60, 0, 0, 12));
    tbl.push_back(mk(1, 3'b111, 8'h67, 0, 0, 8, 1, 8'h60, 0, 0, 15));
    tbl.push_back(mk(1, 3'b001, 8'h68, 0, 0, 8, 1, 8'h60, 0, 0, 15));
    tbl.push_back(mk(1, 3'b111, 8'h69, 0, 0, 8, 1, 8'h60, 0, 0, 15));
    run_tbl("flush_sat");

    // Asynchronous reset between clock edges, with the FIFO full and a drop pending.
    drive(1'b1, 3'b000, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    check_head("async_rst", 4'd0, 1'b0, 8'h00, 2'd0, 1'b0, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 3'b001, 8'h70, 1'b0, 1'b0);
    cycle();
    check_head("post_rst", 4'd1, 1'b1, 8'h70, 2'd0, 1'b0, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/swerv_trace_fifo.md
# swerv_trace_fifo

Parametrised retire-trace buffer between the decode/commit trace outputs and an external trace sink. Accepts up to LANES retired-instruction records per cycle (the packed trace packet format, generalised in lane count) and stores them in program order in a DEPTH-entry FIFO. Records drain one per cycle over a valid/ready port. When a group does not fit, the whole group is dropped; the loss is counted and marked on the next stored record.

## Interface
- LANES, default 3: retire lanes per cycle, 1..4.
- DEPTH, default 8: FIFO entries; power of two, DEPTH >= LANES.
- CNTW, default 16: width of the drop counter.
- clk  in  1: core clock.
- rst  in  1: asynchronous reset, active-high.
- trace_en  in  1: capture enable.
- flush  in  1: synchronous clear of the FIFO, the overflow flag and the counter.
- in_valid  in  LANES: per-lane retire valid; bit i is lane i.
- in_insn  in  32*LANES: instruction words; lane i occupies [32i+31:32i].
- in_addr  in  32*LANES: instruction addresses, same packing as in_insn.
- in_exception  in  LANES: per-lane exception.
- in_interrupt  in  LANES: per-lane interrupt.
- in_ecause  in  5: cause, shared by all lanes.
- in_tval  in  32: trap value, shared by all lanes.
- out_valid  out  1: FIFO non-empty.
- out_ready  in  1: sink accepts the head record.
- out_insn  out  32, out_addr  out  32: head record instruction word and address.
- out_exception  out  1, out_interrupt  out  1: head record trap flags.
- out_ecause  out  5, out_tval  out  32: head record cause and trap value.
- out_lane  out  2: source lane of the head record.
- out_ovf  out  1: one or more records were dropped immediately before this record.
- drop_cnt  out  CNTW: saturating count of dropped records.
- count  out  $clog2(DEPTH+1): current occupancy.

## Operation
- Group size n = popcount(in_valid & {LANES{trace_en}}).
- Push condition: n <= DEPTH - count. Free space is computed from the count at the start of the cycle; a pop in the same cycle is not credited.
- On push, valid lanes are written in ascending lane index to consecutive entries starting at the write pointer. Invalid lanes are compacted out, so there are no gaps.
- Per-entry contents: insn, addr, exception, interrupt, lane index.
- ecause and tval: stored only in the entry whose lane has exception or interrupt set. All other entries store 0.
- If n > free space and n > 0, the whole group is dropped: no entry is written, drop_cnt += n (saturates at all-ones), and ovf_pending is set.
- On the next accepted non-empty group, the first written entry stores ovf = 1, then ovf_pending clears. If that same cycle also drops, ovf_pending stays set.
- Pop: when out_valid && out_ready, the read pointer advances by 1.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Next count = count + n_pushed - popped.
- The out_* fields are driven combinationally from the head entry. When out_valid = 0 they are 0.
- flush has priority over push and pop in the same cycle. It clears both pointers, count, ovf_pending and drop_cnt; input data that cycle is discarded.
- When trace_en = 0, no pushes or drops occur and the FIFO keeps draining.

## Timing
- Reset values: pointers, count, ovf_pending and drop_cnt are 0. out_valid = 0 and all out_* fields are 0.
- Latency: a record pushed in cycle t appears at the head no earlier than cycle t+1.
- Throughput: LANES records per cycle in, 1 record per cycle out.
- Full (count == DEPTH): out_valid = 1. Any group with n >= 1 is dropped, even if a pop occurs in that cycle.
- Empty: out_ready is ignored.
- Simultaneous push and pop at count == DEPTH-1 with n = 1: push accepted, count stays DEPTH-1.
- Reset asserted mid-operation: all state clears asynchronously, and in-flight records are lost without being counted.

## Test plan
- Reset, then LANES = 3 with in_valid = 3'b101, insn A and C, out_ready = 1 -> cycle+1 head is A (lane 0), cycle+2 head is C (lane 2), out_ovf = 0, count returns to 0.
- out_ready = 0, then push 3-lane groups until count = 6 of DEPTH 8, then push 3'b111 -> group dropped, drop_cnt = 3, count stays 6. Push 3'b001 -> accepted with ovf = 1 stored. Drain and check out_ovf = 1 only on that record.
- Lane 1 carries an exception with ecause = 5'd2 and tval = 32'hDEAD_BEEF, lane 0 is valid without a trap -> the lane 0 record shows ecause = 0 and tval = 0; the lane 1 record shows 2 and 32'hDEADBEEF.
- Push 1 record per cycle and pop 1 per cycle over 20 cycles -> pointers wrap, order is preserved, count is steady at 1.
- Fill the FIFO, assert flush together with in_valid = 3'b111 -> next cycle count = 0, out_valid = 0, drop_cnt = 0.
- Force drop_cnt near saturation (CNTW = 4: cause 15 drops, then one more) -> drop_cnt holds at 4'hF.
